// File: rtl/aes128_package.sv
// Shared definitions for the masked AES datapath: share bookkeeping,
// LFSR constants and the randomness-source state type.
package aes128_package;

    // Number of pairwise random elements consumed by one masked multiply.
    function automatic int num_quad(input int num_shares);
        return (num_shares * (num_shares - 1)) / 2;
    endfunction

    localparam logic [31:0] LFSR_POLY_MASK  = 32'h80200003;
    localparam logic [31:0] LFSR_ZERO_SUBST = 32'h00000001;

    typedef enum logic [1:0] {
        RS_SEED   = 2'd0,
        RS_WARMUP = 2'd1,
        RS_RUN    = 2'd2
    } rand_state_t;

endpackage

// File: rtl/galois_lfsr_step.sv
// Pure combinational STEPS-fold advance of a 32-bit Galois LFSR
// (x^32+x^22+x^2+x+1, right-shifting form).
module galois_lfsr_step
    import aes128_package::*;
#(
    parameter int STEPS = 32
) (
    input  logic [31:0] i_state,
    output logic [31:0] o_state
);

    logic [31:0] w_state;

    always_comb begin
        w_state = i_state;
        for (int k = 0; k < STEPS; k++) begin
            w_state = w_state[0] ? ((w_state >> 1) ^ LFSR_POLY_MASK) : (w_state >> 1);
        end
    end

    assign o_state = w_state;

endmodule

// File: rtl/masked_rand_source.sv
// Seeded LFSR bank producing fresh r/p masking words for one masked
// multiplier draw per valid/ready handshake; a draw is never shown twice.
module masked_rand_source
    import aes128_package::*;
#(
    parameter int NUM_SHARES     = 2,
    parameter int BIT_WIDTH      = 4,
    parameter int STEPS_PER_DRAW = 32,
    parameter int WARMUP_DRAWS   = 4,
    localparam int NUM_QUAD      = num_quad(NUM_SHARES),
    localparam int R_BITS        = NUM_QUAD * BIT_WIDTH
) (
    input  logic              in_clock,
    input  logic              in_reset,
    input  logic [31:0]       in_seed,
    input  logic              in_seed_valid,
    output logic              out_seed_ready,
    input  logic              in_reseed,
    output logic [R_BITS-1:0] out_r,
    output logic [R_BITS-1:0] out_p,
    output logic              out_valid,
    input  logic              in_ready
);

    localparam int TOTAL     = 2 * R_BITS;
    localparam int NUM_LANES = (TOTAL + 31) / 32;
    localparam int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CNT_W     = (WARMUP_DRAWS > 1) ? $clog2(WARMUP_DRAWS) : 1;

    rand_state_t      r_state;
    rand_state_t      w_next_state;
    logic [31:0]      r_lane      [NUM_LANES];
    logic [31:0]      w_lane_next [NUM_LANES];
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [TOTAL-1:0] w_stream;

    logic w_seed_xfer;
    logic w_last_seed;
    logic w_warm_done;
    logic w_advance;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            galois_lfsr_step #(.STEPS(STEPS_PER_DRAW)) u_step (
                .i_state (r_lane[g]),
                .o_state (w_lane_next[g])
            );
            // The top lane is only partially visible when TOTAL is not a multiple of 32.
            if ((g + 1) * 32 <= TOTAL) begin : g_full
                assign w_stream[g*32 +: 32] = r_lane[g];
            end else begin : g_part
                assign w_stream[TOTAL-1:g*32] = r_lane[g][TOTAL-1-g*32:0];
            end
        end
    endgenerate

    assign w_seed_xfer = (r_state == RS_SEED) && in_seed_valid && !in_reseed;
    assign w_last_seed = w_seed_xfer && (r_idx == IDX_W'(NUM_LANES - 1));
    assign w_warm_done = (r_state == RS_WARMUP) && (int'(r_cnt) == WARMUP_DRAWS - 1);
    assign w_advance   = (r_state == RS_WARMUP) || ((r_state == RS_RUN) && in_ready);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RS_SEED:   if (w_last_seed) w_next_state = (WARMUP_DRAWS == 0) ? RS_RUN : RS_WARMUP;
            RS_WARMUP: if (w_warm_done) w_next_state = RS_RUN;
            RS_RUN:    w_next_state = RS_RUN;
            default:   w_next_state = RS_SEED;
        endcase
        if (in_reseed) w_next_state = RS_SEED;
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            r_state <= RS_SEED;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (in_reseed)        r_idx <= '0;
            else if (w_seed_xfer) r_idx <= w_last_seed ? '0 : r_idx + IDX_W'(1);
            if ((r_state == RS_WARMUP) && !w_warm_done && !in_reseed) r_cnt <= r_cnt + CNT_W'(1);
            else                                                      r_cnt <= '0;
        end
    end

    // A consume coinciding with reseed still advances, so that draw is burned.
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            for (int k = 0; k < NUM_LANES; k++) r_lane[k] <= LFSR_ZERO_SUBST;
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (w_advance)
                    r_lane[k] <= w_lane_next[k];
                else if (w_seed_xfer && (r_idx == IDX_W'(k)))
                    r_lane[k] <= (in_seed == 32'h0) ? LFSR_ZERO_SUBST : in_seed;
            end
        end
    end

    assign out_seed_ready = (r_state == RS_SEED) && !in_reset;
    assign out_valid      = (r_state == RS_RUN) && !in_reset;
    assign out_r          = w_stream[R_BITS-1:0];
    assign out_p          = w_stream[TOTAL-1:R_BITS];

endmodule
